// File: rtl/score_pkg.sv
// Shared types and constants for the two-player BCD score counter:
// FSM states, winner codes, BCD digit format and the saturating increment.
package score_pkg;

  localparam int DIGIT_W  = 4;
  localparam int NUM_BTNS = 3;
  localparam int BTN_P1   = 0;
  localparam int BTN_P2   = 1;
  localparam int BTN_CLR  = 2;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_TIE  = 2'b11
  } winner_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd_t;

  // Two-digit BCD increment that saturates at 99.
  function automatic bcd_t bcd_inc(input bcd_t v);
    bcd_t r;
    r = v;
    if (v.ones < DIGIT_MAX) begin
      r.ones = v.ones + DIGIT_W'(1);
    end else if (v.tens < DIGIT_MAX) begin
      r.tens = v.tens + DIGIT_W'(1);
      r.ones = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_if.sv
// Button inputs and score/status outputs of the score counter, grouped as one bus.
// The board/bench side is the master; score_counter is the slave.
interface score_if;
  import score_pkg::*;

  logic               p1_btn_i;
  logic               p2_btn_i;
  logic               clr_btn_i;
  logic [DIGIT_W-1:0] p1_tens_o;
  logic [DIGIT_W-1:0] p1_ones_o;
  logic [DIGIT_W-1:0] p2_tens_o;
  logic [DIGIT_W-1:0] p2_ones_o;
  logic               game_over_o;
  winner_t            winner_o;

  modport master (
    output p1_btn_i, p2_btn_i, clr_btn_i,
    input  p1_tens_o, p1_ones_o, p2_tens_o, p2_ones_o, game_over_o, winner_o
  );

  modport slave (
    input  p1_btn_i, p2_btn_i, clr_btn_i,
    output p1_tens_o, p1_ones_o, p2_tens_o, p2_ones_o, game_over_o, winner_o
  );
endinterface

// File: rtl/score_counter_debounce.sv
// Button conditioner: 2-FF synchronizer, consecutive-cycle debounce counter and
// a registered single-cycle pulse on each rising edge of the debounced level.
module debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk_1khz,
  input  logic rst_i,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_MS < 2) ? 1 : $clog2(DEBOUNCE_MS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             pulse_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk_1khz or negedge rst_i) begin
    if (!rst_i) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      pulse_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      pulse_reg <= 1'b0;
      // Any cycle where the synchronized value agrees with the level restarts the count.
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= sync2_reg;
        pulse_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/score_counter.sv
// Two-player BCD score keeper: debounced score/clear buttons feed a PLAY/OVER
// FSM that ends the game when a score reaches WIN_SCORE and reports the winner.
module score_counter
  import score_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int WIN_SCORE   = 21
) (
  input  logic    clk_1khz,
  input  logic    rst_i,
  score_if.slave  bus
);

  localparam bcd_t WIN_BCD = '{tens: DIGIT_W'(WIN_SCORE / 10),
                               ones: DIGIT_W'(WIN_SCORE % 10)};

  logic [NUM_BTNS-1:0] btn_vec;
  logic [NUM_BTNS-1:0] pulse_vec;

  state_t  state_reg, state_next;
  bcd_t    p1_reg, p1_next;
  bcd_t    p2_reg, p2_next;
  winner_t winner_reg, winner_next;
  logic    hit1, hit2;

  assign btn_vec[BTN_P1]  = bus.p1_btn_i;
  assign btn_vec[BTN_P2]  = bus.p2_btn_i;
  assign btn_vec[BTN_CLR] = bus.clr_btn_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_debounce (
        .clk_1khz (clk_1khz),
        .rst_i    (rst_i),
        .btn      (btn_vec[gi]),
        .pulse    (pulse_vec[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_1khz or negedge rst_i) begin
    if (!rst_i) begin
      state_reg  <= ST_PLAY;
      p1_reg     <= '0;
      p2_reg     <= '0;
      winner_reg <= WIN_NONE;
    end else begin
      state_reg  <= state_next;
      p1_reg     <= p1_next;
      p2_reg     <= p2_next;
      winner_reg <= winner_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    p1_next     = p1_reg;
    p2_next     = p2_reg;
    winner_next = winner_reg;
    hit1        = 1'b0;
    hit2        = 1'b0;
    // Clear wins over any increment arriving in the same cycle.
    if (pulse_vec[BTN_CLR]) begin
      state_next  = ST_PLAY;
      p1_next     = '0;
      p2_next     = '0;
      winner_next = WIN_NONE;
    end else begin
      case (state_reg)
        ST_PLAY: begin
          if (pulse_vec[BTN_P1]) begin
            p1_next = bcd_inc(p1_reg);
            hit1    = (p1_next == WIN_BCD);
          end
          if (pulse_vec[BTN_P2]) begin
            p2_next = bcd_inc(p2_reg);
            hit2    = (p2_next == WIN_BCD);
          end
          if (hit1 || hit2) begin
            state_next  = ST_OVER;
            winner_next = winner_t'({hit2, hit1});
          end
        end
        default: begin
          state_next = state_reg;
        end
      endcase
    end
  end

  // state_t is one bit with OVER=1, so this is the state flop itself.
  assign bus.game_over_o = (state_reg == ST_OVER);
  assign bus.winner_o    = winner_reg;
  assign bus.p1_tens_o   = p1_reg.tens;
  assign bus.p1_ones_o   = p1_reg.ones;
  assign bus.p2_tens_o   = p2_reg.tens;
  assign bus.p2_ones_o   = p2_reg.ones;

endmodule

// File: tb/tb_score_counter.sv
// Self-checking bench for score_counter: directed game scenarios plus random
// presses and glitch bursts, compared against an integer-score reference model.
module tb_score_counter;
  import score_pkg::*;

  localparam int D   = 20;
  localparam int WIN = 21;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  score_if bus ();
  score_if bus99 ();

  score_counter #(.DEBOUNCE_MS(D), .WIN_SCORE(WIN)) dut (
    .clk_1khz (clk),
    .rst_i    (rst_n),
    .bus      (bus.slave)
  );

  score_counter #(.DEBOUNCE_MS(D), .WIN_SCORE(99)) dut99 (
    .clk_1khz (clk),
    .rst_i    (rst_n),
    .bus      (bus99.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: plain integer scores and game status.
  int m_s1 = 0, m_s2 = 0, m_win = 0;
  bit m_over = 0;
  int n_s1 = 0;
  bit n_over = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " p1_tens"}, 32'(bus.p1_tens_o), m_s1 / 10);
    chk({tag, " p1_ones"}, 32'(bus.p1_ones_o), m_s1 % 10);
    chk({tag, " p2_tens"}, 32'(bus.p2_tens_o), m_s2 / 10);
    chk({tag, " p2_ones"}, 32'(bus.p2_ones_o), m_s2 % 10);
    chk({tag, " game_over"}, 32'(bus.game_over_o), 32'(m_over));
    chk({tag, " winner"}, 32'(bus.winner_o), m_win);
    $display("step %-10s p1=%0d%0d p2=%0d%0d over=%0b winner=%0d", tag,
             bus.p1_tens_o, bus.p1_ones_o, bus.p2_tens_o, bus.p2_ones_o,
             bus.game_over_o, bus.winner_o);
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_over = 0; m_win = 0;
    n_s1 = 0; n_over = 0;
  endtask

  task automatic model_apply(input bit a, input bit b, input bit c);
    bit w1, w2;
    w1 = 0; w2 = 0;
    if (c) begin
      m_s1 = 0; m_s2 = 0; m_over = 0; m_win = 0;
    end else if (!m_over) begin
      if (a) begin
        if (m_s1 < 99) m_s1++;
        w1 = (m_s1 == WIN);
      end
      if (b) begin
        if (m_s2 < 99) m_s2++;
        w2 = (m_s2 == WIN);
      end
      if (w1 || w2) begin
        m_over = 1;
        m_win  = (w1 ? 1 : 0) + (w2 ? 2 : 0);
      end
    end
  endtask

  // Clean press: checks the edge before and the edge of the expected update,
  // then that holding and releasing produce nothing further.
  task automatic press(input bit a, input bit b, input bit c, input int hold);
    @(negedge clk);
    bus.p1_btn_i = a; bus.p2_btn_i = b; bus.clr_btn_i = c;
    repeat (D + 2) @(negedge clk);
    chk_all("pre-edge");
    @(negedge clk);
    model_apply(a, b, c);
    chk_all("press");
    repeat (hold) @(negedge clk);
    chk_all("hold");
    bus.p1_btn_i = 0; bus.p2_btn_i = 0; bus.clr_btn_i = 0;
    repeat (D + 5) @(negedge clk);
    chk_all("release");
  endtask

  task automatic press99();
    @(negedge clk);
    bus99.p1_btn_i = 1;
    repeat (D + 3) @(negedge clk);
    if (!n_over) begin
      if (n_s1 < 99) n_s1++;
      if (n_s1 == 99) n_over = 1;
    end
    chk("w99 p1_tens", 32'(bus99.p1_tens_o), n_s1 / 10);
    chk("w99 p1_ones", 32'(bus99.p1_ones_o), n_s1 % 10);
    bus99.p1_btn_i = 0;
    repeat (D + 5) @(negedge clk);
  endtask

  initial begin
    int r;
    int len;
    bus.p1_btn_i = 0; bus.p2_btn_i = 0; bus.clr_btn_i = 0;
    bus99.p1_btn_i = 0; bus99.p2_btn_i = 0; bus99.clr_btn_i = 0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk_all("reset");
    rst_n = 1;
    repeat (3) @(negedge clk);

    // First clean press held 40 cycles: exactly 23 edges of latency
    press(1, 0, 0, 17);

    // p2 toggling every 5 cycles never debounces
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) bus.p2_btn_i = ~bus.p2_btn_i;
      @(negedge clk);
    end
    bus.p2_btn_i = 0;
    repeat (D + 5) @(negedge clk);
    chk_all("toggle");

    // Random glitch bursts shorter than the debounce window
    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(1, D - 2);
      bus.p1_btn_i = $urandom_range(0, 1);
      bus.p2_btn_i = $urandom_range(0, 1);
      repeat (len) @(negedge clk);
      bus.p1_btn_i = 0; bus.p2_btn_i = 0;
      repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    repeat (D + 5) @(negedge clk);
    chk_all("glitch");

    // Clear, then 09 -> 10 carry
    press(0, 0, 1, 2);
    for (int i = 0; i < 10; i++) press(1, 0, 0, 2);

    // Build 20-20, then a simultaneous win
    for (int i = 0; i < 10; i++) press(1, 0, 0, 2);
    for (int i = 0; i < 20; i++) press(0, 1, 0, 2);
    press(1, 1, 0, 2);
    press(1, 0, 0, 2);

    // Clear together with p1 in OVER: clear wins
    press(1, 0, 1, 2);
    repeat (10) @(negedge clk);
    chk_all("clr-prio");

    // Reset mid-game and mid-debounce, button held across release
    press(1, 0, 0, 2);
    press(0, 1, 0, 2);
    @(negedge clk);
    bus.p1_btn_i = 1;
    repeat (10) @(negedge clk);
    rst_n = 0;
    #1;
    model_reset();
    chk_all("in-reset");
    repeat (3) @(negedge clk);
    chk_all("in-reset2");
    rst_n = 1;
    repeat (D + 2) @(negedge clk);
    chk_all("rst-pre");
    @(negedge clk);
    model_apply(1, 0, 0);
    chk_all("rst-press");
    bus.p1_btn_i = 0;
    repeat (D + 5) @(negedge clk);
    chk_all("rst-rel");

    // Random presses against the model
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0)       press($urandom_range(0, 1), 0, 1, 1);
      else if (r < 9)   press(1, 0, 0, $urandom_range(0, 10));
      else if (r < 17)  press(0, 1, 0, $urandom_range(0, 10));
      else              press(1, 1, 0, $urandom_range(0, 10));
    end

    // WIN_SCORE=99: 100 presses, score stops at 99
    for (int i = 0; i < 100; i++) press99();
    chk("w99 game_over", 32'(bus99.game_over_o), 32'(n_over));
    chk("w99 winner", 32'(bus99.winner_o), 1);
    chk("w99 p2_ones", 32'(bus99.p2_ones_o), 0);
    $display("step w99       p1=%0d%0d over=%0b", bus99.p1_tens_o, bus99.p1_ones_o,
             bus99.game_over_o);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
